uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
Command sequencer between the UART receiver and the logic-analyzer capture core. Parses fixed 5-byte command frames from received bytes, validates them and updates the capture configuration registers. Issues one-cycle arm/abort strobes to the capture core. Reports per-frame ok/error status back to the host-side logic.

Parameters:
DIV_RST, 16'd1, reset value of cfg_div
DEPTH_RST, 16'd1024, reset value of cfg_depth
TIMEOUT, 20'd400000, max clk cycles allowed between bytes of one frame
SYNC, 8'hA5, frame start byte

Ports:
clk  in  1  system clock, all logic on rising edge
nreset  in  1  asynchronous reset, active low
rx_data  in  8  received byte, valid only while rx_valid=1
rx_valid  in  1  one-cycle strobe, byte available (already synchronised to clk)
rx_err  in  1  receiver framing error, level
cfg_div  out  16  sample clock divider
cfg_trig_mask  out  8  trigger channel mask
cfg_trig_val  out  8  trigger compare value
cfg_depth  out  16  capture depth in samples
arm  out  1  one-cycle strobe, start capture
abort  out  1  one-cycle strobe, stop capture
cmd_ok  out  1  one-cycle strobe, frame accepted
cmd_err  out  1  one-cycle strobe, frame rejected
busy  out  1  1 while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, nreset=0): state=IDLE, cfg_div=DIV_RST, cfg_trig_mask=8'h00, cfg_trig_val=8'h00, cfg_depth=DEPTH_RST, all strobes 0, busy 0, timeout counter 0.
- Frame: SYNC, CMD, ARG_HI, ARG_LO, CHK. CHK = CMD ^ ARG_HI ^ ARG_LO.
- FSM states: IDLE, GET_CMD, GET_AH, GET_AL, GET_CHK, EXEC.
- IDLE: rx_valid with rx_data==SYNC -> GET_CMD. Any other byte is ignored silently; no strobe.
- GET_CMD/GET_AH/GET_AL: each rx_valid stores the byte and advances. GET_CHK: rx_valid -> compare; match -> EXEC, mismatch -> cmd_err pulse, IDLE.
- EXEC (exactly one cycle, entered the cycle after the CHK byte) decodes CMD:
  - 8'h01: cfg_div <= {AH,AL}; an arg of 0 is illegal -> cmd_err, cfg_div unchanged.
  - 8'h02: cfg_trig_mask <= AL (AH ignored).
  - 8'h03: cfg_trig_val <= AL.
  - 8'h04: cfg_depth <= {AH,AL}; 0 illegal -> cmd_err.
  - 8'h10: arm pulse.
  - 8'h11: abort pulse.
  - Other opcodes: cmd_err.
  - Legal command: cmd_ok and the register update or strobe happen in the same cycle (registered outputs, valid the cycle after EXEC).
  - Returns to IDLE. rx_valid arriving during EXEC is treated as received in IDLE, so no byte is lost.
- Latency: CHK strobe at cycle N; registers, arm/abort and cmd_ok/cmd_err are visible at cycle N+2.
- Timeout:
  - The counter resets on every rx_valid and counts while state is GET_*.
  - Reaching TIMEOUT-1 -> cmd_err, IDLE, partial frame discarded.
  - The counter saturates and does not wrap.
- rx_err=1 in any GET_* state -> cmd_err pulse, IDLE. In IDLE, rx_err is ignored.
- Simultaneous rx_err and rx_valid: rx_err wins and the byte is discarded.
- Strobes never overlap. cmd_ok and cmd_err are mutually exclusive. At most one of arm/abort is asserted in any cycle.
- A SYNC value appearing inside a frame is treated as data, not as a resync.
- nreset asserted mid-frame: immediate return to reset values. Config registers are lost.

Test Plan:
- Reset, then frame A5 01 00 0A 0B -> 2 cycles after CHK: cfg_div=16'h000A, cmd_ok=1 for exactly 1 cycle; busy 1 from the CMD byte until EXEC.
- Frame A5 10 00 00 10 -> arm=1 for 1 cycle, cmd_ok=1 for 1 cycle. Then A5 11 00 00 11 -> abort=1 for 1 cycle.
- Bad checksum A5 02 00 F0 00 -> cmd_err=1 for 1 cycle, cfg_trig_mask stays 8'h00. Bytes 3C 55 while IDLE -> no strobes at all.
- A5 04 00 00 04 -> cmd_err, cfg_depth stays 1024. A5 7E 00 00 7E -> cmd_err.
- A5 03 then silence for TIMEOUT cycles -> cmd_err, busy=0. Next frame A5 03 00 81 82 -> cfg_trig_val=8'h81.
- rx_err during GET_AL -> cmd_err, IDLE. nreset pulsed mid-frame -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses 5-byte command frames (SYNC, CMD, ARG_HI, ARG_LO, CHK)
// from the UART receiver and drives the capture configuration and strobes.
module uart_cmd_ctrl #(
  parameter logic [15:0] DIV_RST   = 16'd1,
  parameter logic [15:0] DEPTH_RST = 16'd1024,
  parameter logic [19:0] TIMEOUT   = 20'd400000,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [15:0] cfg_div,
  output logic [7:0]  cfg_trig_mask,
  output logic [7:0]  cfg_trig_val,
  output logic [15:0] cfg_depth,
  output logic        arm,
  output logic        abort,
  output logic        cmd_ok,
  output logic        cmd_err,
  output logic        busy
);

  localparam int unsigned TMO_W = 20;

  localparam logic [7:0] OP_DIV   = 8'h01;
  localparam logic [7:0] OP_MASK  = 8'h02;
  localparam logic [7:0] OP_VAL   = 8'h03;
  localparam logic [7:0] OP_DEPTH = 8'h04;
  localparam logic [7:0] OP_ARM   = 8'h10;
  localparam logic [7:0] OP_ABORT = 8'h11;

  typedef enum logic [2:0] {
    S_IDLE, S_GET_CMD, S_GET_AH, S_GET_AL, S_GET_CHK, S_EXEC
  } state_e;

  state_e           state_q;
  logic [7:0]       cmd_q, ah_q, al_q;
  logic [TMO_W-1:0] tmo_q;
  logic [15:0]      div_q, depth_q;
  logic [7:0]       mask_q, val_q;
  logic             arm_q, abort_q, ok_q, err_q;

  // Frame parser, inter-byte timeout and command execution
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      ah_q    <= '0;
      al_q    <= '0;
      tmo_q   <= '0;
      div_q   <= DIV_RST;
      depth_q <= DEPTH_RST;
      mask_q  <= '0;
      val_q   <= '0;
      arm_q   <= 1'b0;
      abort_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      arm_q   <= 1'b0;
      abort_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tmo_q <= '0;
          if (rx_valid && rx_data == SYNC) state_q <= S_GET_CMD;
        end
        S_GET_CMD, S_GET_AH, S_GET_AL, S_GET_CHK: begin
          if (rx_err) begin
            // a framing error aborts the frame and drops any byte presented with it
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_IDLE;
          end else if (rx_valid) begin
            tmo_q <= '0;
            case (state_q)
              S_GET_CMD: begin cmd_q <= rx_data; state_q <= S_GET_AH; end
              S_GET_AH:  begin ah_q  <= rx_data; state_q <= S_GET_AL; end
              S_GET_AL:  begin al_q  <= rx_data; state_q <= S_GET_CHK; end
              S_GET_CHK: begin
                if (rx_data == (cmd_q ^ ah_q ^ al_q)) begin
                  state_q <= S_EXEC;
                end else begin
                  err_q   <= 1'b1;
                  state_q <= S_IDLE;
                end
              end
              default:   state_q <= S_IDLE;
            endcase
          end else if (tmo_q >= TIMEOUT - TMO_W'(1)) begin
            err_q   <= 1'b1;
            tmo_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_EXEC: begin
          tmo_q <= '0;
          // a byte arriving here is handled as if already back in IDLE
          state_q <= (rx_valid && rx_data == SYNC) ? S_GET_CMD : S_IDLE;
          case (cmd_q)
            OP_DIV: begin
              if ({ah_q, al_q} == 16'h0000) begin
                err_q <= 1'b1;
              end else begin
                div_q <= {ah_q, al_q};
                ok_q  <= 1'b1;
              end
            end
            OP_MASK:  begin mask_q <= al_q; ok_q <= 1'b1; end
            OP_VAL:   begin val_q  <= al_q; ok_q <= 1'b1; end
            OP_DEPTH: begin
              if ({ah_q, al_q} == 16'h0000) begin
                err_q <= 1'b1;
              end else begin
                depth_q <= {ah_q, al_q};
                ok_q    <= 1'b1;
              end
            end
            OP_ARM:   begin arm_q   <= 1'b1; ok_q <= 1'b1; end
            OP_ABORT: begin abort_q <= 1'b1; ok_q <= 1'b1; end
            default:  err_q <= 1'b1;
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_div       = div_q;
  assign cfg_trig_mask = mask_q;
  assign cfg_trig_val  = val_q;
  assign cfg_depth     = depth_q;
  assign arm           = arm_q;
  assign abort         = abort_q;
  assign cmd_ok        = ok_q;
  assign cmd_err       = err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with hand-computed expectations.
module tb_uart_cmd_ctrl;

  logic        clk;
  logic        nreset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_trig_mask;
  logic [7:0]  cfg_trig_val;
  logic [15:0] cfg_depth;
  logic        arm, abort, cmd_ok, cmd_err, busy;

  int checks = 0;
  int errors = 0;

  uart_cmd_ctrl #(.TIMEOUT(20'd16)) dut (
    .clk           (clk),
    .nreset        (nreset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_err        (rx_err),
    .cfg_div       (cfg_div),
    .cfg_trig_mask (cfg_trig_mask),
    .cfg_trig_val  (cfg_trig_val),
    .cfg_depth     (cfg_depth),
    .arm           (arm),
    .abort         (abort),
    .cmd_ok        (cmd_ok),
    .cmd_err       (cmd_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(h);
    send_byte(l);
    send_byte(k);
  endtask

  // strobes must never overlap
  always @(negedge clk) begin
    if (nreset) check("excl", 32'((cmd_ok & cmd_err) | (arm & abort)), 32'd0);
  end

  initial begin
    nreset   = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    step();

    check("rst_div",   32'(cfg_div), 32'h1);
    check("rst_depth", 32'(cfg_depth), 32'd1024);
    check("rst_mask",  32'(cfg_trig_mask), 32'h0);
    check("rst_val",   32'(cfg_trig_val), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_strb",  32'({arm, abort, cmd_ok, cmd_err}), 32'h0);

    // set divider: strobes and register appear two cycles after CHK
    send_byte(8'hA5);
    check("div_busy_sync", 32'(busy), 32'h1);
    send_byte(8'h01);
    check("div_busy_cmd", 32'(busy), 32'h1);
    send_byte(8'h00);
    send_byte(8'h0A);
    send_byte(8'h0B);
    check("div_busy_exec", 32'(busy), 32'h1);
    check("div_ok_early",  32'(cmd_ok), 32'h0);
    check("div_early",     32'(cfg_div), 32'h1);
    step();
    check("div_ok",  32'(cmd_ok), 32'h1);
    check("div_val", 32'(cfg_div), 32'h000A);
    step();
    check("div_ok_pulse", 32'(cmd_ok), 32'h0);
    check("div_busy_end", 32'(busy), 32'h0);

    // arm then abort
    send_frame(8'h10, 8'h00, 8'h00, 8'h10);
    step();
    check("arm",    32'(arm), 32'h1);
    check("arm_ok", 32'(cmd_ok), 32'h1);
    step();
    check("arm_pulse", 32'({arm, cmd_ok}), 32'h0);
    send_frame(8'h11, 8'h00, 8'h00, 8'h11);
    step();
    check("abort",     32'({abort, arm, cmd_ok}), 32'b101);
    step();
    check("abort_pulse", 32'(abort), 32'h0);

    // bad checksum: rejected right after CHK
    send_frame(8'h02, 8'h00, 8'hF0, 8'h00);
    check("badchk_err",  32'(cmd_err), 32'h1);
    check("badchk_busy", 32'(busy), 32'h0);
    step();
    check("badchk_pulse", 32'(cmd_err), 32'h0);
    check("badchk_mask",  32'(cfg_trig_mask), 32'h0);

    // junk while idle is silent
    send_byte(8'h3C);
    send_byte(8'h55);
    for (int i = 0; i < 3; i++) begin
      check("idle_junk", 32'({busy, arm, abort, cmd_ok, cmd_err}), 32'h0);
      step();
    end

    // illegal depth and unknown opcode
    send_frame(8'h04, 8'h00, 8'h00, 8'h04);
    step();
    check("depth0_err", 32'({cmd_ok, cmd_err}), 32'b01);
    check("depth0_val", 32'(cfg_depth), 32'd1024);
    send_frame(8'h7E, 8'h00, 8'h00, 8'h7E);
    step();
    check("badop_err", 32'({cmd_ok, cmd_err}), 32'b01);
    step();
    check("badop_pulse", 32'(cmd_err), 32'h0);

    // inter-byte timeout (TIMEOUT=16 here)
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (15) step();
    check("tmo_not_yet", 32'({busy, cmd_err}), 32'b10);
    step();
    check("tmo_err", 32'({busy, cmd_err}), 32'b01);

    // trig value, with the next SYNC landing in the EXEC cycle
    send_frame(8'h03, 8'h00, 8'h81, 8'h82);
    send_byte(8'hA5);
    check("val_ok",    32'(cmd_ok), 32'h1);
    check("val_val",   32'(cfg_trig_val), 32'h81);
    check("exec_sync", 32'(busy), 32'h1);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    step();
    check("exec_sync_arm", 32'({arm, cmd_ok}), 32'b11);

    // SYNC value inside a frame is data
    send_frame(8'h02, 8'hA5, 8'hA5, 8'h02);
    step();
    check("sync_data_ok",   32'(cmd_ok), 32'h1);
    check("sync_data_mask", 32'(cfg_trig_mask), 32'hA5);

    // rx_err in GET_AL
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    rx_err = 1'b1;
    step();
    rx_err = 1'b0;
    check("rxerr_err",  32'({busy, cmd_err}), 32'b01);
    check("rxerr_mask", 32'(cfg_trig_mask), 32'hA5);

    // rx_err together with rx_valid drops the byte
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    rx_err   = 1'b1;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    step();
    rx_err   = 1'b0;
    rx_valid = 1'b0;
    check("errvalid_err", 32'({busy, cmd_err}), 32'b01);

    // async reset mid-frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    #3 nreset = 1'b0;
    #1;
    check("arst_div",   32'(cfg_div), 32'h1);
    check("arst_busy",  32'(busy), 32'h0);
    check("arst_cfg",   32'({cfg_trig_mask, cfg_trig_val}), 32'h0);
    check("arst_depth", 32'(cfg_depth), 32'd1024);
    step();
    nreset = 1'b1;
    step();
    send_frame(8'h01, 8'h12, 8'h34, 8'h27);
    step();
    check("post_rst_ok",  32'(cmd_ok), 32'h1);
    check("post_rst_div", 32'(cfg_div), 32'h1234);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
